// File: rtl/oam_dma_ctrl.sv
// OAM DMA controller: copies OAM_LEN bytes from page {src,00} into OAM, one byte per M-cycle.
// Optional OAM_DMA_ECHO_EN folds source pages E0-FF onto C0-DF (echo RAM).
module oam_dma_ctrl #(
    parameter int unsigned OAM_LEN = 160,
    parameter logic [15:0] DMA_REG = 16'hFF46
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_write,
    input  logic [7:0]  bus_rdata,
    output logic [15:0] bus_addr,
    output logic        bus_write,
    output logic        cpu_blocked,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_wdata,
    output logic        oam_write,
    output logic        dma_active,
    output logic [7:0]  reg_rdata
);

    localparam logic [7:0] LAST_IDX = 8'(OAM_LEN - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        XFER  = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] src_q, src_d;
    logic [7:0] src_eff;
    logic       reg_wr;

    // A DMA_REG write in any state (re)starts the transfer and outranks the XFER step.
    assign reg_wr = ce && cpu_write && (cpu_addr == DMA_REG);

`ifdef OAM_DMA_ECHO_EN
    assign src_eff = (src_q >= 8'hE0) ? (src_q & 8'hDF) : src_q;
`else
    assign src_eff = src_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            idx_q   <= 8'h00;
            src_q   <= 8'hFF;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            src_q   <= src_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        src_d   = src_q;
        if (ce) begin
            if (reg_wr) begin
                src_d   = cpu_wdata;
                idx_d   = 8'h00;
                state_d = START;
            end else begin
                unique case (state_q)
                    START: state_d = XFER;
                    XFER: begin
                        if (idx_q == LAST_IDX) begin
                            idx_d   = 8'h00;
                            state_d = IDLE;
                        end else begin
                            idx_d = idx_q + 8'h01;
                        end
                    end
                    default: state_d = state_q;
                endcase
            end
        end
    end

    // Bus arbitration and OAM strobe; the CPU owns the bus everywhere except XFER.
    always_comb begin
        bus_addr    = cpu_addr;
        bus_write   = cpu_write;
        cpu_blocked = 1'b0;
        oam_write   = 1'b0;
        oam_addr    = idx_q;
        oam_wdata   = bus_rdata;
        dma_active  = (state_q != IDLE);
        reg_rdata   = src_q;
        if (state_q == XFER) begin
            bus_addr    = {src_eff, idx_q};
            bus_write   = 1'b0;
            cpu_blocked = (cpu_addr[15:8] != 8'hFF);
            oam_write   = rst && ce && !reg_wr;
        end
    end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Randomized bench for oam_dma_ctrl against a ce-count based reference model.
module tb_oam_dma_ctrl;

    localparam int unsigned OAM_LEN = 160;

    logic        clk = 1'b0;
    logic        rst, ce, cpu_write;
    logic [15:0] cpu_addr, bus_addr;
    logic [7:0]  cpu_wdata, bus_rdata, oam_addr, oam_wdata, reg_rdata;
    logic        bus_write, cpu_blocked, oam_write, dma_active;

    int n_checks = 0;
    int n_fail   = 0;
    int n_wr     = 0;

    // Reference model: whether a transfer is live, ce clks since the trigger clk, and source page.
    bit         m_act = 1'b0;
    int         m_cnt = 0;
    logic [7:0] m_src = 8'hFF;

    always #5 clk = ~clk;

    // Memory stand-in: read data is a scramble of the address presented on the bus.
    assign bus_rdata = bus_addr[15:8] ^ {bus_addr[6:0], bus_addr[7]};

    oam_dma_ctrl #(.OAM_LEN(OAM_LEN), .DMA_REG(16'hFF46)) dut (
        .clk(clk), .rst(rst), .ce(ce),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_write(cpu_write),
        .bus_rdata(bus_rdata), .bus_addr(bus_addr), .bus_write(bus_write),
        .cpu_blocked(cpu_blocked), .oam_addr(oam_addr), .oam_wdata(oam_wdata),
        .oam_write(oam_write), .dma_active(dma_active), .reg_rdata(reg_rdata)
    );

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] page_of(input logic [7:0] s);
`ifdef OAM_DMA_ECHO_EN
        return (s >= 8'hE0) ? (s - 8'h20) : s;
`else
        return s;
`endif
    endfunction

    function automatic logic [15:0] rand_addr();
        logic [15:0] a;
        a = 16'($urandom);
        if ($urandom_range(3) == 0) a[15:8] = 8'hFF;
        if (a == 16'hFF46) a = 16'hFF47;
        return a;
    endfunction

    // One clk: drive at negedge, check the model's view just after, then advance the model.
    task automatic step(input logic ce_v, input logic rst_v, input logic [15:0] a,
                        input logic [7:0] d, input logic w);
        bit          in_x, trig;
        logic [7:0]  eidx;
        logic [15:0] eaddr;
        @(negedge clk);
        ce = ce_v; rst = rst_v; cpu_addr = a; cpu_wdata = d; cpu_write = w;
        #1;
        in_x  = m_act && (m_cnt >= 1);
        eidx  = in_x ? 8'(m_cnt - 1) : 8'h00;
        eaddr = in_x ? {page_of(m_src), eidx} : a;
        trig  = ce_v && w && (a == 16'hFF46);
        check_eq("bus_addr",    bus_addr,    eaddr);
        check_eq("bus_write",   16'(bus_write),   16'(in_x ? 1'b0 : w));
        check_eq("cpu_blocked", 16'(cpu_blocked), 16'(in_x && (a[15:8] != 8'hFF)));
        check_eq("oam_write",   16'(oam_write),   16'(rst_v && ce_v && in_x && !trig));
        check_eq("oam_addr",    16'(oam_addr),    16'(eidx));
        check_eq("oam_wdata",   16'(oam_wdata),   16'(eaddr[15:8] ^ {eaddr[6:0], eaddr[7]}));
        check_eq("dma_active",  16'(dma_active),  16'(m_act));
        check_eq("reg_rdata",   16'(reg_rdata),   16'(m_src));
        if (oam_write) n_wr++;
        if (!rst_v) begin
            m_act = 1'b0; m_cnt = 0; m_src = 8'hFF;
        end else if (trig) begin
            m_act = 1'b1; m_cnt = 0; m_src = d;
        end else if (ce_v && m_act) begin
            m_cnt++;
            if (m_cnt > OAM_LEN) m_act = 1'b0;
        end
    endtask

    task automatic run(input int n, input int ce_period);
        for (int i = 0; i < n; i++)
            step((i % ce_period) == 0, 1'b1, rand_addr(), 8'($urandom), 1'($urandom));
    endtask

    task automatic trigger(input logic [7:0] v);
        step(1'b1, 1'b1, 16'hFF46, v, 1'b1);
    endtask

    initial begin
        rst = 1'b0; ce = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00; cpu_write = 1'b0;
        repeat (2) @(posedge clk);
        step(1'b1, 1'b0, 16'h1234, 8'h00, 1'b0);
        run(4, 1);

        // Full transfer from C1: 160 strobes, idle again 162 ce clks after the write clk.
        n_wr = 0;
        trigger(8'hC1);
        run(170, 1);
        check_eq("pulse_count", 16'(n_wr), 16'(OAM_LEN));

        // CPU traffic during XFER: low address blocked, high page not, writes suppressed.
        trigger(8'h40);
        run(3, 1);
        step(1'b1, 1'b1, 16'h0000, 8'h00, 1'b0);
        step(1'b1, 1'b1, 16'hFF80, 8'h00, 1'b0);
        step(1'b1, 1'b1, 16'hC000, 8'h5A, 1'b1);
        run(170, 1);

        // Restart at idx 50 with page 80.
        trigger(8'h30);
        run(51, 1);
        trigger(8'h80);
        run(170, 1);

        // Reset at idx 100 kills the transfer.
        trigger(8'hC1);
        run(101, 1);
        step(1'b1, 1'b0, rand_addr(), 8'h00, 1'b0);
        n_wr = 0;
        run(30, 1);
        check_eq("writes_after_rst", 16'(n_wr), 16'd0);

        // Echo-range source page.
        trigger(8'hE2);
        run(170, 1);

        // ce every 4th clk.
        n_wr = 0;
        trigger(8'hD0);
        run(700, 4);
        check_eq("pulse_count_ce4", 16'(n_wr), 16'(OAM_LEN));

        // Random mix of ce, restarts and resets.
        for (int i = 0; i < 3000; i++)
            step(1'($urandom_range(2) != 0), 1'($urandom_range(199) != 0),
                 ($urandom_range(39) == 0) ? 16'hFF46 : rand_addr(),
                 8'($urandom), 1'($urandom));

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
